// File: rtl/puf_pkg.sv
// ---- puf_pkg: shared types and sizing helpers for the PUF CRP controller ----
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package puf_pkg;

  localparam int CW_DEF = 16;
  localparam int RW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Wide enough to hold NEVAL itself, so a vote counter never wraps.
  function automatic int vote_cnt_w(input int neval);
    return $clog2(neval + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/puf_bit_vote.sv
// ---- puf_bit_vote: one response bit's ones counter with majority/unanimity ----
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module puf_bit_vote
  import puf_pkg::*;
#(
  parameter int NEVAL = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic bit_i,
  output logic maj_o,
  output logic stable_o
);

  localparam int CNTW = vote_cnt_w(NEVAL);
  localparam logic [CNTW-1:0] HALF = CNTW'(NEVAL / 2);
  localparam logic [CNTW-1:0] ALL  = CNTW'(NEVAL);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNTW'(inc_i & bit_i);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Judged on the next count so the verdict already includes the final sample.
  assign maj_o    = (cnt_d > HALF);
  assign stable_o = (cnt_d == '0) || (cnt_d == ALL);

endmodule

`default_nettype wire

// File: rtl/puf_crp_ctrl.sv
// ---- puf_crp_ctrl: issues a challenge, fires NEVAL pulses, returns voted response ----
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module puf_crp_ctrl
  import puf_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int RW      = RW_DEF,
  parameter int NEVAL   = 5,
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_challenge,
  output logic [CW-1:0] puf_challenge,
  output logic          puf_pulse,
  input  logic [RW-1:0] puf_response,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [CW-1:0] rsp_challenge,
  output logic [RW-1:0] rsp_response,
  output logic [RW-1:0] rsp_stable
);

  localparam int EW  = vote_cnt_w(NEVAL);
  localparam int PHW = $clog2(((PULSE_W > SETTLE) ? PULSE_W : SETTLE) + 1);

  state_e           state_q, state_d;
  logic [PHW-1:0]   phase_q, phase_d;
  logic [EW-1:0]    eval_q, eval_d;
  logic [CW-1:0]    puf_challenge_q;
  logic [CW-1:0]    rsp_challenge_q;
  logic [RW-1:0]    rsp_response_q;
  logic [RW-1:0]    rsp_stable_q;
  logic             accept, sample_en, last;
  logic [RW-1:0]    maj, stab;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    puf_pulse = 1'b0;
    accept    = 1'b0;
    sample_en = 1'b0;
    last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_PULSE;
      ST_PULSE: begin
        puf_pulse = 1'b1;
        if (phase_q == PHW'(PULSE_W - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (phase_q == PHW'(SETTLE - 1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (eval_q == EW'(NEVAL - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase counter times both the pulse and settle windows, restarting on every state change.
  always_comb begin
    phase_d = '0;
    if ((state_q == ST_PULSE || state_q == ST_SETTLE) && state_d == state_q)
      phase_d = phase_q + 1'b1;
    eval_d = eval_q;
    if (accept)         eval_d = '0;
    else if (sample_en) eval_d = eval_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      eval_q          <= '0;
      puf_challenge_q <= '0;
      rsp_challenge_q <= '0;
      rsp_response_q  <= '0;
      rsp_stable_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      eval_q  <= eval_d;
      if (accept) puf_challenge_q <= req_challenge;
      if (last) begin
        rsp_challenge_q <= puf_challenge_q;
        rsp_response_q  <= maj;
        rsp_stable_q    <= stab;
      end
    end
  end

  for (genvar i = 0; i < RW; i++) begin : g_vote
    puf_bit_vote #(.NEVAL(NEVAL)) u_vote (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (accept),
      .inc_i    (sample_en),
      .bit_i    (puf_response[i]),
      .maj_o    (maj[i]),
      .stable_o (stab[i])
    );
  end

  assign puf_challenge = puf_challenge_q;
  assign rsp_challenge = rsp_challenge_q;
  assign rsp_response  = rsp_response_q;
  assign rsp_stable    = rsp_stable_q;

endmodule

`default_nettype wire

// File: tb/tb_puf_crp_ctrl.sv
// ---- tb_puf_crp_ctrl: table-driven and randomized bench for puf_crp_ctrl ----
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_puf_crp_ctrl;

  localparam int CW      = 16;
  localparam int RW      = 16;
  localparam int NEVAL   = 5;
  localparam int PULSE_W = 2;
  localparam int SETTLE  = 4;
  localparam int LAT     = NEVAL * (2 + PULSE_W + SETTLE) + 1;

  typedef logic [NEVAL-1:0][15:0] smp_t;

  typedef struct packed {
    logic [15:0] ch;
    smp_t        smp;
    logic [15:0] exp_resp;
    logic [15:0] exp_stab;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_challenge;
  logic [CW-1:0] puf_challenge;
  logic          puf_pulse;
  logic [RW-1:0] puf_response;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [CW-1:0] rsp_challenge;
  logic [RW-1:0] rsp_response;
  logic [RW-1:0] rsp_stable;

  int checks = 0;
  int errors = 0;

  int          npulse = 0;
  int          pw = 0;
  int          pw_bad = 0;
  int          ch_bad = 0;
  logic        prev_pulse = 1'b0;
  bit          pw_en = 1'b1;
  bit          busy = 1'b0;
  logic [15:0] exp_ch = '0;
  int          base = 0;
  smp_t        cur_smp = '0;

  vec_t vecs[8];

  puf_crp_ctrl #(
    .CW(CW), .RW(RW), .NEVAL(NEVAL), .PULSE_W(PULSE_W), .SETTLE(SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_challenge (rsp_challenge),
    .rsp_response  (rsp_response),
    .rsp_stable    (rsp_stable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Array model: the k-th pulse since the request started selects the k-th sample.
  always_comb begin
    int idx;
    idx = npulse - base;
    puf_response = '0;
    if (idx > 0) puf_response = cur_smp[(idx - 1) % NEVAL];
  end

  always @(negedge clk) begin
    if (puf_pulse && !prev_pulse) begin
      npulse = npulse + 1;
      pw = 1;
    end else if (puf_pulse) begin
      pw = pw + 1;
    end else if (prev_pulse && pw_en && pw != PULSE_W) begin
      pw_bad = pw_bad + 1;
    end
    if (busy && puf_challenge !== exp_ch) ch_bad = ch_bad + 1;
    prev_pulse = puf_pulse;
  end

  function automatic logic [31:0] vote_model(input smp_t s);
    logic [15:0] r, st;
    int n;
    for (int b = 0; b < 16; b++) begin
      n = 0;
      for (int k = 0; k < NEVAL; k++) n += int'(s[k][b]);
      r[b]  = (2 * n > NEVAL);
      st[b] = (n == 0) || (n == NEVAL);
    end
    return {r, st};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic accept_req(input logic [15:0] ch, input smp_t s);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    base          = npulse;
    cur_smp       = s;
    exp_ch        = ch;
    req_valid     = 1'b1;
    req_challenge = ch;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    busy      = 1'b1;
  endtask

  // Entered at the negedge of cycle 1 after the accept edge.
  task automatic finish_req(input logic [15:0] ch, input logic [15:0] er,
                            input logic [15:0] es, input int bp);
    int k;
    int n0;
    bit bp_ok;
    k = 1;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(LAT));
    chk("rsp_response", 32'(rsp_response), 32'(er));
    chk("rsp_stable", 32'(rsp_stable), 32'(es));
    chk("rsp_challenge", 32'(rsp_challenge), 32'(ch));
    chk("pulse_count", 32'(npulse - base), 32'(NEVAL));
    chk("pulse_width_errs", 32'(pw_bad), 32'd0);
    chk("challenge_stable_errs", 32'(ch_bad), 32'd0);
    n0    = npulse;
    bp_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      bp_ok = bp_ok && rsp_valid && !req_ready && !puf_pulse && (npulse == n0) &&
              (rsp_response == er) && (rsp_stable == es) && (rsp_challenge == ch);
    end
    if (bp > 0) chk("backpressure_hold", 32'(bp_ok), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    busy      = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
    chk("post_hs_hold", 32'(rsp_response), 32'(er));
  endtask

  initial begin
    logic [31:0] m;
    smp_t        s;
    logic [15:0] cv;
    int          w, cyc, acc1, acc2, hs1, nres;
    bit          saw;

    rst_n         = 1'b0;
    req_valid     = 1'b0;
    rsp_ready     = 1'b0;
    req_challenge = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_puf_pulse", 32'(puf_pulse), 32'd0);
    chk("rst_puf_challenge", 32'(puf_challenge), 32'd0);
    chk("rst_rsp_response", 32'(rsp_response), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    vecs[0] = '{ch: 16'hA5C3, smp: {5{16'h1234}}, exp_resp: 16'h1234, exp_stab: 16'hFFFF};
    vecs[1] = '{ch: 16'h0F0F, smp: {16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0001},
                exp_resp: 16'h0001, exp_stab: 16'hFFFC};
    vecs[2] = '{ch: 16'h1357, smp: {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF},
                exp_resp: 16'hFFFF, exp_stab: 16'h0000};
    for (int i = 3; i < 8; i++) begin
      vecs[i].ch = 16'($urandom);
      for (int k = 0; k < NEVAL; k++) vecs[i].smp[k] = 16'($urandom);
      m = vote_model(vecs[i].smp);
      vecs[i].exp_resp = m[31:16];
      vecs[i].exp_stab = m[15:0];
    end

    for (int i = 0; i < 8; i++) begin
      accept_req(vecs[i].ch, vecs[i].smp);
      finish_req(vecs[i].ch, vecs[i].exp_resp, vecs[i].exp_stab, (i == 0) ? 10 : (i % 3));
    end

    // Abort in the middle of the third pulse.
    for (int k = 0; k < NEVAL; k++) s[k] = 16'($urandom);
    accept_req(16'h7777, s);
    w = 0;
    while (!((npulse - base) == 3 && puf_pulse) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("reach_pulse3", 32'(w < 100), 32'd1);
    pw_en = 1'b0;
    busy  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pulse_low", 32'(puf_pulse), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_puf_challenge", 32'(puf_challenge), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk("abort_no_rsp", 32'(saw), 32'd0);
    pw_en = 1'b1;
    cv = 16'($urandom);
    accept_req(16'h00FF, {5{cv}});
    finish_req(16'h00FF, cv, 16'hFFFF, 0);

    // Back-to-back requests with req_valid held high.
    for (int k = 0; k < NEVAL; k++) s[k] = 16'($urandom);
    m = vote_model(s);
    @(negedge clk);
    base          = npulse;
    cur_smp       = s;
    req_valid     = 1'b1;
    req_challenge = 16'h0001;
    rsp_ready     = 1'b1;
    cyc = 0; acc1 = -1; acc2 = -1; hs1 = -1; nres = 0;
    while (nres < 2 && cyc < 300) begin
      if (req_valid && req_ready) begin
        if (acc1 < 0) acc1 = cyc;
        else          acc2 = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        nres++;
        if (hs1 < 0) hs1 = cyc;
        chk("b2b_challenge", 32'(rsp_challenge), (nres == 1) ? 32'h0001 : 32'h0002);
        chk("b2b_response", 32'(rsp_response), 32'(m[31:16]));
        chk("b2b_stable", 32'(rsp_stable), 32'(m[15:0]));
      end
      if (acc1 >= 0 && cyc == acc1 + 1) req_challenge = 16'h0002;
      if (acc2 >= 0 && cyc == acc2 + 1) req_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_results", 32'(nres), 32'd2);
    chk("b2b_gap", 32'(acc2 - hs1), 32'd1);
    chk("b2b_first_latency", 32'(hs1 - acc1), 32'(LAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
